// File: rtl/project_activation_gate.sv
// Sequenced activation gate between the harness select line and one user project slot.
// Define ACTIVATION_COUNTER_EN to build the saturating activation counter on act_count_o.
module project_activation_gate #(
  parameter int NUM_IO       = 38,
  parameter int LA_WIDTH     = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                active,
  input  logic [NUM_IO-1:0]   proj_io_out_i,
  input  logic [NUM_IO-1:0]   proj_io_oeb_i,
  input  logic [LA_WIDTH-1:0] proj_la_out_i,
  output logic                proj_rst_o,
  output logic [NUM_IO-1:0]   io_out,
  output logic [NUM_IO-1:0]   io_oeb,
  output logic [LA_WIDTH-1:0] la_data_out,
  output logic [1:0]          state_o,
  output logic                running_o,
  output logic [15:0]         act_count_o
);

  localparam int MAX_CYCLES = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF        = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic                   run_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   active_q;

  // The select line is asynchronous to this slot, so only the last synchroniser stage is trusted.
  if (SYNC_STAGES == 1) begin : g_sync_single
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= active;
    end
  end else begin : g_sync_chain
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], active};
    end
  end

  assign active_q = sync_q[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= OFF;
      count <= '0;
      run_q <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (active_q) begin
            state <= RESET_HOLD;
            count <= RESET_LOAD;
          end
        end
        RESET_HOLD: begin
          // Losing the select wins over an expiring hold so a short pulse never reaches RUN.
          if (!active_q) begin
            state <= DRAIN;
            count <= DRAIN_LOAD;
          end else if (count == '0) begin
            state <= RUN;
            run_q <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        RUN: begin
          if (!active_q) begin
            state <= DRAIN;
            count <= DRAIN_LOAD;
            run_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (count == '0) state <= OFF;
          else             count <= count - 1'b1;
        end
        default: begin
          state <= OFF;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  logic                drive;
  logic [NUM_IO-1:0]   io_out_d;
  logic [NUM_IO-1:0]   io_oeb_d;
  logic [LA_WIDTH-1:0] la_d;

  assign drive       = (state != OFF);
  assign io_out_d    = run_q ? proj_io_out_i : '0;
  assign io_oeb_d    = run_q ? proj_io_oeb_i : '1;
  assign la_d        = run_q ? proj_la_out_i : '0;
  assign proj_rst_o  = ~run_q;
  assign running_o   = run_q;
  assign state_o     = state;

  // An inactive slot releases the shared bus; formal builds see zeros instead of high-Z.
`ifdef FORMAL
  assign io_out      = drive ? io_out_d : '0;
  assign io_oeb      = drive ? io_oeb_d : '0;
  assign la_data_out = drive ? la_d : '0;
`else
  assign io_out      = drive ? io_out_d : 'z;
  assign io_oeb      = drive ? io_oeb_d : 'z;
  assign la_data_out = drive ? la_d : 'z;
`endif

`ifdef ACTIVATION_COUNTER_EN
  logic [15:0] act_count;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      act_count <= '0;
    end else if (state == OFF && active_q && act_count != 16'hFFFF) begin
      act_count <= act_count + 16'd1;
    end
  end

  assign act_count_o = act_count;
`else
  assign act_count_o = 16'h0;
`endif

endmodule
